// File: rtl/regbank_writeback_if.sv
// Write-request and bank-destination handshake for the register-bank writeback queue.
interface regbank_writeback_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          bank_ready;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  modport master (
    input  in_valid, in_addr, in_data, bank_ready,
    output in_ready, wb_en, wb_addr, wb_data
  );

  modport slave (
    output in_valid, in_addr, in_data, bank_ready,
    input  in_ready, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/regbank_writeback.sv
// In-order write queue feeding the 8x8 register bank destination port.
// Optional operand forwarding from queued writes: define REGBANK_WB_FWD_EN.
module regbank_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  regbank_writeback_if.master      bus,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     idle,
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_data1,
  output logic [DW-1:0]            fwd_data2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic            push, pop;

  // State mirrors count so handshake outputs come straight from registers.
  always_comb begin
    push    = bus.in_valid && (state_q != FULL);
    pop     = (state_q != EMPTY) && bus.bank_ready;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    state_d = ACTIVE;
    if (count_d == '0)
      state_d = EMPTY;
    else if (count_d == CW'(DEPTH))
      state_d = FULL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= EMPTY;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= '{addr: bus.in_addr, data: bus.in_data};
  end

  assign bus.in_ready = (state_q != FULL);
  assign bus.wb_en    = (state_q != EMPTY);
  // Gate with wb_en so stale (unreset) storage never leaks onto the bus.
  assign bus.wb_addr  = bus.wb_en ? mem[head_q].addr : '0;
  assign bus.wb_data  = bus.wb_en ? mem[head_q].data : '0;
  assign idle         = (state_q == EMPTY);
  assign pending      = count_q;

`ifdef REGBANK_WB_FWD_EN
  // Scan oldest to newest so the youngest match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (mem[head_q + PW'(i)].addr == rd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem[head_q + PW'(i)].data;
        end
        if (mem[head_q + PW'(i)].addr == rd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem[head_q + PW'(i)].data;
        end
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_addr1, rd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regbank_writeback.sv
// Directed bench for regbank_writeback with a scoreboard of expected bank writes.
module tb_regbank_writeback;
  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    pending;
  logic          idle;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;

  regbank_writeback_if #(.AW(AW), .DW(DW)) bus ();

  regbank_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pending(pending), .idle(idle),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  pass_cnt = 0;
  int  fail_cnt = 0;
  int  total    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    if (accept) sb.push_back('{addr: a, data: d});
  endtask

  // Every accepted bank write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.wb_en === 1'b1 && bus.bank_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(bus.wb_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wb_addr_order", 32'(bus.wb_addr), 32'(e.addr));
        check("wb_data_order", 32'(bus.wb_data), 32'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0; bus.bank_ready = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    check("rst_wb_en", 32'(bus.wb_en), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_idle", 32'(idle), 1);
    check("rst_pending", 32'(pending), 0);
    check("rst_wb_addr", 32'(bus.wb_addr), 0);
    check("rst_wb_data", 32'(bus.wb_data), 0);

    // Single write: visible one cycle after push, gone the cycle after.
    bus.bank_ready = 1'b1;
    drive_push(3'd3, 8'hA5, 1);
    check("no_bypass_wb_en", 32'(bus.wb_en), 0);
    step();
    bus.in_valid = 1'b0;
    check("single_wb_en", 32'(bus.wb_en), 1);
    check("single_wb_addr", 32'(bus.wb_addr), 3);
    check("single_wb_data", 32'(bus.wb_data), 32'hA5);
    step();
    check("single_idle", 32'(idle), 1);

    // Fill against a stalled bank, then overflow attempt.
    bus.bank_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_push(AW'(i), DW'(i * 17), 1);
      step();
    end
    check("full_pending", 32'(pending), 4);
    check("full_in_ready", 32'(bus.in_ready), 0);
    check("stall_hold_addr", 32'(bus.wb_addr), 1);
    check("stall_hold_data", 32'(bus.wb_data), 32'h11);
    drive_push(3'd5, 8'h55, 0);
    step();
    bus.in_valid = 1'b0;
    check("overflow_pending", 32'(pending), 4);
    bus.bank_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_wb_en", 32'(bus.wb_en), 1);
      step();
    end
    check("drain_idle", 32'(idle), 1);

    // Steady state at two entries with push and pop every cycle.
    bus.bank_ready = 1'b0;
    drive_push(3'd0, 8'h80, 1); step();
    drive_push(3'd1, 8'h81, 1); step();
    bus.bank_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(AW'(i + 2), DW'(8'h90 + i), 1);
      step();
      check("steady_pending", 32'(pending), 2);
    end
    bus.in_valid = 1'b0;
    step(); step();
    check("steady_idle", 32'(idle), 1);

    // Forwarding: newest match wins; same-cycle push invisible.
    bus.bank_ready = 1'b0;
    rd_addr1 = 3'd6; rd_addr2 = 3'd2;
    drive_push(3'd6, 8'h10, 1); step();
    drive_push(3'd6, 8'h20, 1); step();
    bus.in_valid = 1'b0;
    #1;
`ifdef REGBANK_WB_FWD_EN
    check("fwd_hit1", 32'(fwd_hit1), 1);
    check("fwd_data1", 32'(fwd_data1), 32'h20);
`else
    check("fwd_hit1", 32'(fwd_hit1), 0);
    check("fwd_data1", 32'(fwd_data1), 0);
`endif
    check("fwd_hit2", 32'(fwd_hit2), 0);
    check("fwd_data2", 32'(fwd_data2), 0);
    drive_push(3'd2, 8'h77, 1);
    #1;
    check("fwd_push_invisible", 32'(fwd_hit2), 0);
    step();
    bus.in_valid = 1'b0;
`ifdef REGBANK_WB_FWD_EN
    check("fwd_hit2_after", 32'(fwd_hit2), 1);
    check("fwd_data2_after", 32'(fwd_data2), 32'h77);
`else
    check("fwd_hit2_after", 32'(fwd_hit2), 0);
    check("fwd_data2_after", 32'(fwd_data2), 0);
`endif
    check("pre_rst_pending", 32'(pending), 3);

    // Reset with three queued writes discards them.
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    check("mid_rst_pending", 32'(pending), 0);
    check("mid_rst_wb_en", 32'(bus.wb_en), 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    check("mid_rst_fwd_hit1", 32'(fwd_hit1), 0);
    check("mid_rst_fwd_hit2", 32'(fwd_hit2), 0);
    bus.bank_ready = 1'b1;
    drive_push(3'd5, 8'h5A, 1);
    step();
    bus.in_valid = 1'b0;
    check("post_rst_wb_en", 32'(bus.wb_en), 1);
    check("post_rst_wb_addr", 32'(bus.wb_addr), 5);
    step(); step();
    check("final_idle", 32'(idle), 1);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
